// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial responder: FSM state encoding,
// default operand limit and the reset value of the result register.
package factorial_pkg;

  // Largest n whose factorial fits in a 32-bit result.
  localparam int MAX_N_DEFAULT = 12;

  // Value driven on result out of reset and on an out-of-range request.
  localparam int RESULT_RST = 0;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_DEC   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/factorial_responder_shift_add_mul.sv
// Sequential DATA_WIDTH x N_WIDTH shift-add multiplier. Multiplier bits are
// consumed LSB first, one per step; o_last flags the step that completes it.
module shift_add_mul #(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [N_WIDTH-1:0]    i_b,
  output logic                  o_last,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_prod
);

  localparam int PW = DATA_WIDTH + N_WIDTH;
  localparam int IW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_a;
  logic [N_WIDTH-1:0]    r_b;
  logic [PW-1:0]         r_prod;
  logic [IW-1:0]         r_idx;
  logic                  r_valid;
  logic [PW-1:0]         w_partial;

  // Partial product contributed by the current multiplier bit.
  always_comb begin
    w_partial = '0;
    if (r_b[r_idx]) begin
      w_partial = {{N_WIDTH{1'b0}}, r_a} << r_idx;
    end else begin
      w_partial = '0;
    end
  end

  assign o_last  = (r_idx == IW'(N_WIDTH - 1));
  assign o_valid = r_valid;
  // Callers only ever multiply values whose product fits DATA_WIDTH.
  assign o_prod  = r_prod[DATA_WIDTH-1:0];

  // Operand capture on load, accumulate one partial product per step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_prod  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_step) begin
      r_prod  <= r_prod + w_partial;
      r_idx   <= r_idx + IW'(1);
      r_valid <= o_last;
    end
  end

endmodule

// File: rtl/factorial_responder.sv
// Responder side of the start/done/result factorial handshake. Computes n!
// iteratively: acc starts at 1 and is multiplied by cnt, cnt-1, ... down to 2.
module factorial_responder
  import factorial_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int MAX_N      = MAX_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  error
);

  state_e                r_state, w_state_nxt;
  logic [N_WIDTH-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [DATA_WIDTH-1:0] r_result, w_result_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;
  logic                  w_load, w_step, w_last, w_valid;
  logic [DATA_WIDTH-1:0] w_prod;
  logic                  w_too_big, w_trivial;

  assign w_too_big = (r_cnt > N_WIDTH'(MAX_N));
  assign w_trivial = (r_cnt <= N_WIDTH'(1));

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign error  = r_error;

  shift_add_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_WIDTH   (N_WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (r_acc),
    .i_b    (r_cnt),
    .o_last (w_last),
    .o_valid(w_valid),
    .o_prod (w_prod)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = start ? ST_CHECK : ST_IDLE;
      ST_CHECK: w_state_nxt = (w_too_big || w_trivial) ? ST_DONE : ST_MUL;
      ST_MUL:   w_state_nxt = w_last ? ST_DEC : ST_MUL;
      ST_DEC:   w_state_nxt = ST_CHECK;
      ST_DONE:  w_state_nxt = start ? ST_DONE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and handshake outputs for the upcoming cycle.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_result_nxt = r_result;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_error_nxt  = r_error;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cnt_nxt   = n;
          w_acc_nxt   = DATA_WIDTH'(1);
          w_error_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_CHECK: begin
        if (w_too_big) begin
          w_error_nxt  = 1'b1;
          w_result_nxt = DATA_WIDTH'(RESULT_RST);
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
        end else if (w_trivial) begin
          w_result_nxt = r_acc;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
        end else begin
          w_load = 1'b1;
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
      end
      ST_DEC: begin
        if (w_valid) begin
          w_acc_nxt = w_prod;
        end else begin
          w_acc_nxt = r_acc;
        end
        w_cnt_nxt = r_cnt - N_WIDTH'(1);
      end
      ST_DONE: begin
        if (!start) begin
          w_done_nxt = 1'b0;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= DATA_WIDTH'(RESULT_RST);
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_factorial_responder.sv
// Directed bench for factorial_responder: table of requests plus hand-written
// reset-mid-operation and back-to-back sequences.
module tb_factorial_responder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_res;

  typedef struct {
    logic [3:0]  nv;
    bit          hold;
    logic [3:0]  nchg;
    logic [31:0] res;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  factorial_responder dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request starting at a negedge; returns at the negedge after done falls.
  task automatic req(input logic [3:0] nv, input bit hold, input logic [3:0] nchg,
                     input logic [31:0] er, input bit ee, input int el);
    int k;
    bit held;
    start = 1'b1;
    n     = nv;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("done_low_after_accept", {31'd0, done}, 32'd0);
    n = nchg;
    if (!hold) start = 1'b0;
    k = 0;
    held = 1'b1;
    while (!done && k < 150) begin
      if (result !== prev_res) held = 1'b0;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (k >= 150) $display("FAIL timeout waiting for done n=%0d", nv);
    chk("latency", k, el);
    chk("result_held", {31'd0, held}, 32'd1);
    chk("result", result, er);
    chk("error", {31'd0, error}, {31'd0, ee});
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    prev_res = er;
    if (hold) begin
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("done_held", {31'd0, done}, 32'd1);
      start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_fall", {31'd0, done}, 32'd0);
  endtask

  initial begin
    //        n      hold  nchg   result         err   lat
    tbl[0] = '{4'd5,  1'b1, 4'd5,  32'h00000078, 1'b0, 25};
    tbl[1] = '{4'd12, 1'b0, 4'd12, 32'h1C8CFC00, 1'b0, 67};
    tbl[2] = '{4'd0,  1'b1, 4'd0,  32'd1,        1'b0, 1};
    tbl[3] = '{4'd1,  1'b0, 4'd1,  32'd1,        1'b0, 1};
    tbl[4] = '{4'd13, 1'b0, 4'd13, 32'd0,        1'b1, 1};
    tbl[5] = '{4'd15, 1'b1, 4'd15, 32'd0,        1'b1, 1};
    tbl[6] = '{4'd2,  1'b0, 4'd2,  32'd2,        1'b0, 7};
    tbl[7] = '{4'd3,  1'b0, 4'd7,  32'd6,        1'b0, 13};
    tbl[8] = '{4'd4,  1'b0, 4'd9,  32'h18,       1'b0, 19};

    reset_n  = 1'b0;
    start    = 1'b0;
    n        = 4'd0;
    prev_res = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      req(tbl[i].nv, tbl[i].hold, tbl[i].nchg, tbl[i].res, tbl[i].err, tbl[i].lat);
    end

    // Back-to-back: 3! then 6! with a single IDLE cycle between them.
    req(4'd3, 1'b0, 4'd3, 32'd6, 1'b0, 13);
    req(4'd6, 1'b1, 4'd6, 32'h2D0, 1'b0, 31);

    // Reset in the middle of a multiply for n=7.
    start = 1'b1;
    n     = 4'd7;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    prev_res = 32'd0;
    @(negedge clk);
    chk("postrst_no_done", {31'd0, done}, 32'd0);
    req(4'd3, 1'b0, 4'd3, 32'd6, 1'b0, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
